bag_random_generator: RTL and testbench
=======================================

Name: bag_random_generator

Overview:
- Successor to the union LFSR generator: lfsr_num_p parallel Galois LFSRs, XOR-combined into one union word.
- Union word is turned into range-limited symbols in [0, symbols_p) behind a 1-entry valid/ready output register.
- Optional 7-bag mode: every consecutive group of symbols_p outputs is a permutation of 0..symbols_p-1.
- Feeds the Tetris piece-spawn logic; supports runtime seed load for reproducible games.

Parameters:
- width_p, 8: LFSR and union word width.
- lfsr_num_p, 2: number of LFSRs.
- taps_p, {8'hB8, 8'h8E}: per-LFSR Galois tap mask; each entry is width_p bits.
- symbols_p, 7: output alphabet size. Legal range 2..2^sym_w, where sym_w = $clog2(symbols_p) and sym_w <= width_p.
- max_tries_p, 4: consecutive rejected candidates allowed before the deterministic fallback; must be >= 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- seed_v_i  in  1  load seed_i this cycle.
- seed_i  in  lfsr_num_p*width_p  per-LFSR seed; LFSR k uses slice k.
- mode_i  in  1  0 = free (range-limited only), 1 = bag.
- ready_i  in  1  consumer accepts data_o.
- v_o  out  1  data_o valid.
- data_o  out  sym_w  symbol.
- bag_cnt_o  out  sym_w+1  symbols issued in the current bag.

Behaviour:
- Reset (reset_n_i low, async):
  - LFSR k state = k+1.
  - v_o = 0, data_o = 0, bag mask = 0, bag_cnt_o = 0, try counter = 0.
- LFSRs: every LFSR steps every cycle, except the cycle seed_v_i is high. On that cycle each LFSR loads its seed slice; a zero slice loads 1 (lock-up avoidance).
- Seed load flush, effective next cycle: v_o = 0, mask = 0, bag_cnt_o = 0, try counter = 0. seed_v_i takes priority over a concurrent handshake; that symbol is dropped.
- Candidate: c = low sym_w bits of the XOR of all current LFSR states (registered values).
- Attempt cycle: any cycle with (!v_o || ready_i) && !seed_v_i.
- Accept rule:
  - c < symbols_p, and
  - in bag mode, mask[c] == 0. The mask already includes every symbol loaded earlier, including one leaving via a handshake this cycle.
- On accept:
  - data_o <= c, v_o <= 1.
  - Bag mode: mask[c] <= 1, bag_cnt_o increments.
  - Try counter <= 0.
- On reject with try counter < max_tries_p-1: try counter increments. v_o <= 0 if a handshake occurred this cycle; otherwise v_o holds.
- On reject with try counter == max_tries_p-1: fallback symbol is loaded as if accepted.
  - Bag mode: lowest-index clear bit of the mask (priority encoder).
  - Free mode: c - symbols_p if c >= symbols_p, else c.
- Bag completion: the accept that sets the last mask bit clears mask and bag_cnt_o to 0 instead of setting them.
- Free mode holds mask = 0 and bag_cnt_o = 0. Switching mode_i from 1 to 0 clears the bag next cycle. Switching 0 to 1 starts an empty bag.
- Latency: after reset release or seed load, the first v_o rises within max_tries_p cycles. After a handshake the next symbol is valid within max_tries_p cycles. Back-to-back throughput of 1 per cycle is possible.
- Backpressure: while v_o && !ready_i, data_o, v_o, mask and bag_cnt_o are stable. LFSRs keep stepping.

Decomposition:
- Package tetris_rand_pkg:
  - function sym_width(symbols) returning the sym_w calculation.
  - default tap-mask constants per width.
  - mode enum {RAND_FREE, RAND_BAG}.
- Sub-module lfsr_galois:
  - parameters width_p, taps_p; ports clk_i, reset_n_i, reset value, load_i, load data, state_o.
  - instantiated lfsr_num_p times via generate.
- Top-level contents: union XOR, accept/fallback logic, mask, counters, output register.

Test Plan:
- Reset then release, ready_i=1, mode_i=1 -> v_o=0 during reset; v_o=1 within 4 cycles of release; data_o < 7.
- Bag mode, seed_i={8'd33,8'd75}, ready_i=1, 21 handshakes -> each group of 7 is a permutation of 0..6; bag_cnt_o cycles 1..6,0.
- Same seed loaded twice, 32 handshakes each -> identical sequences; seed_i={8'd0,8'd0} -> both LFSRs load 1, no lock-up (union word changes each cycle).
- ready_i=0 for 20 cycles with v_o=1 -> data_o and bag_cnt_o unchanged; the first symbol after release equals the held value.
- max_tries_p=1, symbols_p=5, bag mode, 50 handshakes -> every 5-group is a permutation of 0..4; a handshake completes within 1 cycle of each attempt.
- Free mode, 100 handshakes -> all data_o < 7, bag_cnt_o=0; seed_v_i asserted together with a handshake -> v_o=0 next cycle and that symbol is not counted.

Source files
------------

// File: rtl/tetris_rand_pkg.sv
// Shared types and helpers for the Tetris piece randomiser.
// Tap masks are right-shift Galois masks; the MSB must be set so a non-zero state never decays to zero.
package tetris_rand_pkg;

    localparam logic [7:0]  TAPS_W8_A = 8'hB8;
    localparam logic [7:0]  TAPS_W8_B = 8'h8E;
    localparam logic [15:0] TAPS_W16  = 16'hB400;

    typedef enum logic {
        RAND_FREE = 1'b0,
        RAND_BAG  = 1'b1
    } rand_mode_e;

    function automatic int sym_width(input int symbols);
        return (symbols < 2) ? 1 : $clog2(symbols);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shift Galois LFSR with parallel load; a zero load value is replaced by 1.
module lfsr_galois #(
    parameter int                 width_p = 8,
    parameter logic [width_p-1:0] taps_p  = 8'hB8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] reset_val_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_data_i,
    output logic [width_p-1:0] state_o
);

    logic [width_p-1:0] state_d, state_q;

    always_comb begin
        if (load_i)
            state_d = (load_data_i == '0) ? width_p'(1) : load_data_i;
        else if (state_q[0])
            state_d = (state_q >> 1) ^ taps_p;
        else
            state_d = state_q >> 1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_q <= reset_val_i;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/bag_random_generator.sv
// Union-LFSR symbol generator with optional bag mode: each group of symbols_p
// outputs is a permutation of 0..symbols_p-1, behind a 1-entry valid/ready register.
module bag_random_generator
    import tetris_rand_pkg::*;
#(
    parameter int                            width_p     = 8,
    parameter int                            lfsr_num_p  = 2,
    parameter logic [lfsr_num_p*width_p-1:0] taps_p      = {TAPS_W8_A, TAPS_W8_B},
    parameter int                            symbols_p   = 7,
    parameter int                            max_tries_p = 4,
    localparam int                           sym_w       = sym_width(symbols_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          seed_v_i,
    input  logic [lfsr_num_p*width_p-1:0] seed_i,
    input  logic                          mode_i,
    input  logic                          ready_i,
    output logic                          v_o,
    output logic [sym_w-1:0]              data_o,
    output logic [sym_w:0]                bag_cnt_o
);

    localparam int                 try_w    = (max_tries_p > 1) ? $clog2(max_tries_p) : 1;
    localparam logic [try_w-1:0]   try_last = try_w'(max_tries_p - 1);
    localparam logic [sym_w:0]     sym_lim  = (sym_w + 1)'(symbols_p);

    logic [lfsr_num_p-1:0][width_p-1:0] lfsr_state;
    logic [width_p-1:0]   union_w;
    logic                 unused_union;
    logic [sym_w-1:0]     cand, bag_fb, free_fb, pick;
    logic [symbols_p-1:0] mask_new;
    logic                 attempt, hs, in_range, accept, fallback;
    rand_mode_e           mode;

    logic                 v_d, v_q;
    logic [sym_w-1:0]     data_d, data_q;
    logic [symbols_p-1:0] mask_d, mask_q;
    logic [sym_w:0]       cnt_d, cnt_q;
    logic [try_w-1:0]     try_d, try_q;

    for (genvar k = 0; k < lfsr_num_p; k++) begin : g_lfsr
        lfsr_galois #(
            .width_p (width_p),
            .taps_p  (taps_p[k*width_p +: width_p])
        ) u_lfsr (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .reset_val_i (width_p'(k + 1)),
            .load_i      (seed_v_i),
            .load_data_i (seed_i[k*width_p +: width_p]),
            .state_o     (lfsr_state[k])
        );
    end

    always_comb begin
        union_w = '0;
        for (int i = 0; i < lfsr_num_p; i++)
            union_w = union_w ^ lfsr_state[i];
    end

    assign unused_union = ^union_w;
    assign cand         = union_w[sym_w-1:0];
    assign mode         = rand_mode_e'(mode_i);
    assign attempt      = (!v_q || ready_i) && !seed_v_i;
    assign hs           = v_q && ready_i;
    assign in_range     = {1'b0, cand} < sym_lim;
    assign accept       = in_range && ((mode == RAND_FREE) || !mask_q[cand]);
    assign fallback     = (try_q == try_last);
    assign free_fb      = in_range ? cand : cand - sym_lim[sym_w-1:0];

    // Mask is never full here (completion clears it), so a clear bit always exists.
    always_comb begin
        bag_fb = '0;
        for (int i = symbols_p - 1; i >= 0; i--)
            if (!mask_q[i])
                bag_fb = sym_w'(i);
    end

    assign pick     = accept ? cand : ((mode == RAND_BAG) ? bag_fb : free_fb);
    assign mask_new = mask_q | (symbols_p'(1) << pick);

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        try_d  = try_q;
        if (seed_v_i) begin
            v_d    = 1'b0;
            mask_d = '0;
            cnt_d  = '0;
            try_d  = '0;
        end else if (attempt) begin
            if (accept || fallback) begin
                data_d = pick;
                v_d    = 1'b1;
                try_d  = '0;
                if (mode == RAND_BAG) begin
                    if (&mask_new) begin
                        mask_d = '0;
                        cnt_d  = '0;
                    end else begin
                        mask_d = mask_new;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end else begin
                try_d = try_q + 1'b1;
                if (hs)
                    v_d = 1'b0;
            end
        end
        if (mode == RAND_FREE) begin
            mask_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            try_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            try_q  <= try_d;
        end
    end

    assign v_o       = v_q;
    assign data_o    = data_q;
    assign bag_cnt_o = cnt_q;

endmodule

// File: tb/tb_bag_random_generator.sv
// Bench for bag_random_generator: two instances (defaults, and symbols=5/max_tries=1)
// share stimulus and are compared every cycle against a behavioural model.
module tb_bag_random_generator;

    logic        clk_i  = 1'b0;
    logic        rst_n  = 1'b1;
    logic        seed_v = 1'b0;
    logic [15:0] seed   = '0;
    logic        mode   = 1'b1;
    logic        ready  = 1'b1;

    logic       va, vb;
    logic [2:0] da, db;
    logic [3:0] ca, cb;

    always #5 clk_i = ~clk_i;

    bag_random_generator u_dut_a (
        .clk_i(clk_i), .reset_n_i(rst_n), .seed_v_i(seed_v), .seed_i(seed),
        .mode_i(mode), .ready_i(ready), .v_o(va), .data_o(da), .bag_cnt_o(ca)
    );

    bag_random_generator #(.symbols_p(5), .max_tries_p(1)) u_dut_b (
        .clk_i(clk_i), .reset_n_i(rst_n), .seed_v_i(seed_v), .seed_i(seed),
        .mode_i(mode), .ready_i(ready), .v_o(vb), .data_o(db), .bag_cnt_o(cb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int SYM[2]   = '{7, 5};
    int TRIES[2] = '{4, 1};
    int TAPS[2]  = '{'h8E, 'hB8};
    int m_lfsr[2][2];
    int m_v[2], m_data[2], m_cnt[2], m_try[2];
    bit m_bag[2][8];

    function automatic int lfsr_next(input int s, input int t);
        return (s & 1) ? ((s >> 1) ^ t) : (s >> 1);
    endfunction

    task automatic clear_bag(input int i);
        for (int j = 0; j < 8; j++) m_bag[i][j] = 1'b0;
        m_cnt[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) m_lfsr[i][k] = k + 1;
            m_v[i] = 0; m_data[i] = 0; m_try[i] = 0;
            clear_bag(i);
        end
    endtask

    task automatic model_step(input int i);
        int c, sym, sl;
        bit ok;
        c = (m_lfsr[i][0] ^ m_lfsr[i][1]) & 7;
        if (seed_v) begin
            for (int k = 0; k < 2; k++) begin
                sl = int'(seed[k*8 +: 8]);
                m_lfsr[i][k] = (sl == 0) ? 1 : sl;
            end
            m_v[i] = 0; m_try[i] = 0;
            clear_bag(i);
        end else begin
            for (int k = 0; k < 2; k++) m_lfsr[i][k] = lfsr_next(m_lfsr[i][k], TAPS[k]);
            if (m_v[i] == 0 || ready) begin
                ok = (c < SYM[i]) && (!mode || !m_bag[i][c]);
                if (ok || m_try[i] == TRIES[i] - 1) begin
                    if (ok) sym = c;
                    else if (mode) begin
                        sym = -1;
                        for (int j = 0; j < SYM[i]; j++)
                            if (sym < 0 && !m_bag[i][j]) sym = j;
                    end else sym = (c >= SYM[i]) ? c - SYM[i] : c;
                    m_data[i] = sym; m_v[i] = 1; m_try[i] = 0;
                    if (mode) begin
                        m_bag[i][sym] = 1'b1;
                        m_cnt[i]++;
                        if (m_cnt[i] == SYM[i]) clear_bag(i);
                    end
                end else begin
                    if (m_v[i] != 0 && ready) m_v[i] = 0;
                    m_try[i]++;
                end
            end
            if (!mode) clear_bag(i);
        end
    endtask

    // ---------------- cycle driver ----------------
    int rec_a[$], rec_b[$], cnt_rec[$];

    task automatic cycle();
        bit hs_a, hs_b, att_a, att_b;
        int sa, sb;
        hs_a  = rst_n && !seed_v && va && ready;
        hs_b  = rst_n && !seed_v && vb && ready;
        att_a = rst_n && !seed_v && (!va || ready);
        att_b = rst_n && !seed_v && (!vb || ready);
        sa = int'(da); sb = int'(db);
        @(posedge clk_i);
        if (rst_n) begin model_step(0); model_step(1); end
        @(negedge clk_i);
        check_eq("a_v",    va, m_v[0]);
        check_eq("a_data", da, m_data[0]);
        check_eq("a_cnt",  ca, m_cnt[0]);
        check_eq("b_v",    vb, m_v[1]);
        check_eq("b_data", db, m_data[1]);
        check_eq("b_cnt",  cb, m_cnt[1]);
        if (att_b) check_eq("b_one_try", vb, 1);
        if (hs_a) rec_a.push_back(sa);
        if (hs_b) rec_b.push_back(sb);
        if (att_a && va) cnt_rec.push_back(int'(ca));
    endtask

    task automatic run_hs(input int n, input int budget, input bit rnd_ready);
        int k = 0;
        while (rec_a.size() < n && k < budget) begin
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle();
            k++;
        end
        check_eq("hs_budget", rec_a.size() >= n, 1);
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed = s; seed_v = 1'b1;
        cycle();
        seed_v = 1'b0;
        rec_a.delete(); rec_b.delete(); cnt_rec.delete();
    endtask

    task automatic perm_check(input string tag, input int q[$], input int n);
        int seen;
        for (int g = 0; g < q.size() / n; g++) begin
            seen = 0;
            for (int j = 0; j < n; j++) seen = seen | (1 << q[g*n + j]);
            check_eq(tag, seen, (1 << n) - 1);
        end
    endtask

    int q1[$];
    int lat, held_d, held_c, nrec;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) cycle();
        check_eq("rst_v_a", va, 0);
        check_eq("rst_v_b", vb, 0);
        check_eq("rst_cnt_a", ca, 0);
        rst_n = 1'b1;
        lat = 0;
        while (!va && lat < 10) begin cycle(); lat++; end
        check_eq("rst_latency_a", (lat >= 1) && (lat <= 4), 1);
        check_eq("rst_range_a", da < 7, 1);

        // bag mode, fixed seed: permutations and bag count 1..6,0
        load_seed({8'd33, 8'd75});
        run_hs(21, 200, 1'b0);
        perm_check("perm7", rec_a, 7);
        perm_check("perm5", rec_b, 5);
        check_eq("perm5_groups", rec_b.size() >= 10, 1);
        for (int j = 0; j < 21 && j < cnt_rec.size(); j++)
            check_eq("bag_cnt_seq", cnt_rec[j], (j + 1) % 7);

        // reproducibility of a reloaded seed
        load_seed(16'hC35A);
        run_hs(32, 300, 1'b0);
        q1 = rec_a;
        load_seed(16'hC35A);
        run_hs(32, 300, 1'b0);
        for (int j = 0; j < 32; j++) check_eq("repeat_seq", rec_a[j], q1[j]);

        // all-zero seed must not lock up
        load_seed(16'h0000);
        run_hs(20, 300, 1'b1);

        // backpressure hold
        ready = 1'b0;
        lat = 0;
        while (!va && lat < 10) begin cycle(); lat++; end
        check_eq("bp_valid", va, 1);
        held_d = int'(da); held_c = int'(ca);
        repeat (20) begin
            cycle();
            check_eq("bp_data", da, held_d);
            check_eq("bp_cnt", ca, held_c);
        end
        rec_a.delete();
        ready = 1'b1;
        cycle();
        check_eq("bp_first", rec_a.size() > 0 ? rec_a[0] : -1, held_d);

        // free mode
        mode = 1'b0;
        rec_a.delete();
        begin
            int k = 0;
            while (rec_a.size() < 100 && k < 1000) begin
                ready = ($urandom_range(0, 3) != 0);
                cycle();
                if (va) check_eq("free_range", da < 7, 1);
                check_eq("free_cnt", ca, 0);
                k++;
            end
            check_eq("free_hs", rec_a.size() >= 100, 1);
        end

        // seed load coinciding with a handshake drops that symbol
        ready = 1'b0;
        lat = 0;
        while (!va && lat < 10) begin cycle(); lat++; end
        check_eq("seed_hs_pre_v", va, 1);
        nrec = rec_a.size();
        ready = 1'b1; seed = 16'($urandom); seed_v = 1'b1;
        cycle();
        seed_v = 1'b0;
        check_eq("seed_hs_v", va, 0);
        check_eq("seed_hs_drop", rec_a.size(), nrec);

        // mixed random traffic
        mode = 1'b1;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            ready  = ($urandom_range(0, 2) != 0);
            seed_v = ($urandom_range(0, 63) == 0);
            seed   = 16'($urandom);
            cycle();
        end
        seed_v = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
